// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: datapath widths, function codes and the
// reservation-station entry layout.
package tomasulo_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned FUN_W  = 3;

    localparam logic [FUN_W-1:0] FUN_MUL = FUN_W'(0);
    localparam logic [FUN_W-1:0] FUN_DIV = FUN_W'(1);

    typedef struct packed {
        logic              valid;
        logic [FUN_W-1:0]  fun3;
        logic [TAG_W-1:0]  des;
        logic              rdy1;
        logic              rdy2;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
    } rs_entry_t;

endpackage

// File: rtl/mul_rs_dispatch_if.sv
// Issue, CDB, unit-completion and dispatch signals between the issue stage,
// the multiply/divide reservation station and the multer array.
interface mul_rs_dispatch_if #(
    parameter int unsigned NUM_ENTRIES = 3,
    parameter int unsigned NUM_FU      = 3
);
    import tomasulo_pkg::*;

    localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

    logic                     flush;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [FUN_W-1:0]         issue_fun3;
    logic [TAG_W-1:0]         issue_des;
    logic                     issue_rdy1;
    logic                     issue_rdy2;
    logic [DATA_W-1:0]        issue_v1;
    logic [DATA_W-1:0]        issue_v2;
    logic [TAG_W-1:0]         issue_tag1;
    logic [TAG_W-1:0]         issue_tag2;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [NUM_FU-1:0]        fu_done;
    logic [NUM_FU-1:0]        disp_fla;
    logic [NUM_FU*DATA_W-1:0] disp_data1;
    logic [NUM_FU*DATA_W-1:0] disp_data2;
    logic [NUM_FU*TAG_W-1:0]  disp_des;
    logic [NUM_FU*FUN_W-1:0]  disp_fun3;
    logic [CNT_W-1:0]         rs_count;

    modport master (
        output flush, issue_valid, issue_fun3, issue_des, issue_rdy1, issue_rdy2,
               issue_v1, issue_v2, issue_tag1, issue_tag2,
               cdb_valid, cdb_tag, cdb_data, fu_done,
        input  issue_ready, disp_fla, disp_data1, disp_data2, disp_des, disp_fun3,
               rs_count
    );

    modport slave (
        input  flush, issue_valid, issue_fun3, issue_des, issue_rdy1, issue_rdy2,
               issue_v1, issue_v2, issue_tag1, issue_tag2,
               cdb_valid, cdb_tag, cdb_data, fu_done,
        output issue_ready, disp_fla, disp_data1, disp_data2, disp_des, disp_fun3,
               rs_count
    );

endinterface

// File: rtl/mul_rs_select.sv
// Age matrix over reservation-station slots plus a one-hot pick of the
// oldest ready candidate.
module mul_rs_select #(
    parameter int unsigned NUM_ENTRIES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_ENTRIES-1:0] alloc,
    input  logic [NUM_ENTRIES-1:0] cand,
    output logic [NUM_ENTRIES-1:0] grant_c
);

    // older_q[i][j] set means slot i was written before slot j
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];

    // A newly written slot is younger than every other slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc[i]) begin
                    older_q[i] <= '0;
                end else begin
                    older_q[i] <= older_q[i] | alloc;
                end
            end
        end
    end

    // A candidate wins when no other candidate is older than it
    always_comb begin
        grant_c = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            grant_c[i] = cand[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (cand[j] && older_q[j][i]) begin
                    grant_c[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mul_rs_dispatch.sv
// Multiply/divide reservation station: operand capture with CDB wakeup and
// oldest-ready dispatch to the lowest-index free multer unit.
module mul_rs_dispatch
    import tomasulo_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 3,
    parameter int unsigned NUM_FU      = 3
) (
    input  logic             clk1,
    input  logic             rst_n,
    mul_rs_dispatch_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

    rs_entry_t              ent_q   [NUM_ENTRIES];
    rs_entry_t              ent_nxt [NUM_ENTRIES];
    rs_entry_t              new_ent_c;
    logic [NUM_ENTRIES-1:0] valid_c;
    logic [NUM_ENTRIES-1:0] cand_c;
    logic [NUM_ENTRIES-1:0] free_c;
    logic [NUM_ENTRIES-1:0] alloc_c;
    logic [NUM_ENTRIES-1:0] grant_c;
    logic [NUM_FU-1:0]      fu_busy_q;
    logic [NUM_FU-1:0]      fu_sel_c;
    logic                   fu_free_c;
    logic                   accept_c;
    logic                   dispatch_c;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_nxt;
    logic                   ready_q;
    logic [DATA_W-1:0]      pick_v1_c;
    logic [DATA_W-1:0]      pick_v2_c;
    logic [TAG_W-1:0]       pick_des_c;
    logic [FUN_W-1:0]       pick_fun3_c;
    logic [NUM_FU-1:0]      fla_q;
    logic [DATA_W-1:0]      data1_q [NUM_FU];
    logic [DATA_W-1:0]      data2_q [NUM_FU];
    logic [TAG_W-1:0]       des_q   [NUM_FU];
    logic [FUN_W-1:0]       fun3_q  [NUM_FU];

    // Incoming instruction, with same-cycle CDB capture for waiting sources
    always_comb begin
        new_ent_c       = '0;
        new_ent_c.valid = 1'b1;
        new_ent_c.fun3  = bus.issue_fun3;
        new_ent_c.des   = bus.issue_des;
        new_ent_c.tag1  = bus.issue_tag1;
        new_ent_c.tag2  = bus.issue_tag2;
        if (bus.issue_rdy1) begin
            new_ent_c.rdy1 = 1'b1;
            new_ent_c.v1   = bus.issue_v1;
        end else if (bus.cdb_valid && (bus.issue_tag1 == bus.cdb_tag)) begin
            new_ent_c.rdy1 = 1'b1;
            new_ent_c.v1   = bus.cdb_data;
        end
        if (bus.issue_rdy2) begin
            new_ent_c.rdy2 = 1'b1;
            new_ent_c.v2   = bus.issue_v2;
        end else if (bus.cdb_valid && (bus.issue_tag2 == bus.cdb_tag)) begin
            new_ent_c.rdy2 = 1'b1;
            new_ent_c.v2   = bus.cdb_data;
        end
    end

    always_comb begin
        valid_c = '0;
        cand_c  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_c[i] = ent_q[i].valid;
            cand_c[i]  = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
        end
    end

    // Lowest clear bit: lowest free slot and lowest idle unit
    assign free_c     = ~valid_c & (valid_c + NUM_ENTRIES'(1));
    assign fu_sel_c   = ~fu_busy_q & (fu_busy_q + NUM_FU'(1));
    assign fu_free_c  = |fu_sel_c;

    assign accept_c   = bus.issue_valid && ready_q && !bus.flush;
    assign alloc_c    = accept_c ? free_c : '0;
    assign dispatch_c = !bus.flush && (|grant_c) && fu_free_c;

    mul_rs_select #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_select (
        .clk     (clk1),
        .rst_n   (rst_n),
        .alloc   (alloc_c),
        .cand    (cand_c),
        .grant_c (grant_c)
    );

    always_comb begin
        pick_v1_c   = '0;
        pick_v2_c   = '0;
        pick_des_c  = '0;
        pick_fun3_c = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant_c[i]) begin
                pick_v1_c   = ent_q[i].v1;
                pick_v2_c   = ent_q[i].v2;
                pick_des_c  = ent_q[i].des;
                pick_fun3_c = ent_q[i].fun3;
            end
        end
    end

    // Per-slot next state: flush, then write, then free, then CDB wakeup
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_nxt[i] = ent_q[i];
            if (bus.flush) begin
                ent_nxt[i].valid = 1'b0;
            end else if (alloc_c[i]) begin
                ent_nxt[i] = new_ent_c;
            end else if (dispatch_c && grant_c[i]) begin
                ent_nxt[i].valid = 1'b0;
            end else if (ent_q[i].valid && bus.cdb_valid) begin
                if (!ent_q[i].rdy1 && (ent_q[i].tag1 == bus.cdb_tag)) begin
                    ent_nxt[i].rdy1 = 1'b1;
                    ent_nxt[i].v1   = bus.cdb_data;
                end
                if (!ent_q[i].rdy2 && (ent_q[i].tag2 == bus.cdb_tag)) begin
                    ent_nxt[i].rdy2 = 1'b1;
                    ent_nxt[i].v2   = bus.cdb_data;
                end
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= ent_nxt[i];
            end
        end
    end

    always_comb begin
        count_nxt = count_q;
        if (bus.flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count_q + CNT_W'(accept_c) - CNT_W'(dispatch_c);
        end
    end

    // Occupancy and ready are registered together so ready never lags the count
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            count_q <= count_nxt;
            ready_q <= (count_nxt != CNT_W'(NUM_ENTRIES));
        end
    end

    // Unit busy flags survive flush; only fu_done releases a unit
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            fu_busy_q <= '0;
            fla_q     <= '0;
        end else begin
            fu_busy_q <= (fu_busy_q & ~bus.fu_done) | (dispatch_c ? fu_sel_c : '0);
            fla_q     <= dispatch_c ? fu_sel_c : '0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FU; k++) begin
                data1_q[k] <= '0;
                data2_q[k] <= '0;
                des_q[k]   <= '0;
                fun3_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (dispatch_c && fu_sel_c[k]) begin
                    data1_q[k] <= pick_v1_c;
                    data2_q[k] <= pick_v2_c;
                    des_q[k]   <= pick_des_c;
                    fun3_q[k]  <= pick_fun3_c;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_unit
        assign bus.disp_data1[k*DATA_W +: DATA_W] = data1_q[k];
        assign bus.disp_data2[k*DATA_W +: DATA_W] = data2_q[k];
        assign bus.disp_des[k*TAG_W +: TAG_W]     = des_q[k];
        assign bus.disp_fun3[k*FUN_W +: FUN_W]    = fun3_q[k];
    end

    assign bus.disp_fla    = fla_q;
    assign bus.issue_ready = ready_q;
    assign bus.rs_count    = count_q;

endmodule
